rr_mux_arb: RTL and testbench
=============================

RR_MUX_ARB -- requirements
Module: rr_mux_arb

Interface
REQ-001 Parameter MAX_HOLD, default 4, range 1..15: maximum consecutive cycles one requester may hold the grant.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  request per requester; bit i = requester i.
REQ-005 data  input  4  one data bit per requester; data[i] is requester i's source.
REQ-006 gnt  output  4  registered one-hot grant, all-zero when idle.
REQ-007 sel  output  2  registered binary index of the granted requester; also the shared mux select.
REQ-008 out  output  1  registered mux output, equal to data[sel] sampled at the previous edge.
REQ-009 out_vld  output  1  registered; high when out carries data of a requester that held the grant and still requested on that edge.

Function
REQ-010 The FSM SHALL have two states: IDLE (no grant) and GRANT (one requester owns the mux).
REQ-011 Arbitration SHALL be round-robin: search starts at index (last+1) mod 4 and ascends with wrap; first set req bit wins; last = most recently granted index.
REQ-012 IDLE with req==0 SHALL stay IDLE, gnt=0, sel unchanged.
REQ-013 IDLE with any req set SHALL move to GRANT on the same edge: gnt/sel = winner, hold_cnt=1, last=winner.
REQ-014 GRANT with req[sel]=1 and hold_cnt<MAX_HOLD SHALL keep the grant and increment hold_cnt.
REQ-015 Release occurs when req[sel]=0, or when hold_cnt==MAX_HOLD; release by drop takes precedence on coincidence.
REQ-016 On release, if any req bit is set, the block SHALL re-arbitrate on the same edge with no idle bubble; the new grant starts with hold_cnt=1.
REQ-017 If, at hold expiry, the current holder is the only requester, it SHALL be re-granted with hold_cnt=1 (search naturally returns it).
REQ-018 On release with req==0 the block SHALL go IDLE: gnt=0, sel holds last value.
REQ-019 Every edge: out <= data[sel] (registered sel value); out_vld <= (state==GRANT && req[sel]).
REQ-020 Grant latency: req sampled at edge N -> gnt/sel valid after N; first out_vld/out after N+1.
REQ-021 gnt SHALL always be one-hot or zero; gnt SHALL equal one-hot(sel) whenever state==GRANT.
REQ-022 hold_cnt SHALL be 4 bits and never exceed MAX_HOLD.
REQ-023 req bits not granted SHALL have no effect on out.

Reset
REQ-024 On rst_n=0, immediately and regardless of clk: state=IDLE, gnt=0, sel=0, last=3, hold_cnt=0, out=0, out_vld=0.
REQ-025 Reset asserted mid-grant SHALL drop the grant; after release the first arbitration favours requester 0.
REQ-026 Outputs SHALL be held at reset values until the first rising edge after rst_n deasserts.

Structure
REQ-027 A shared package SHALL hold the state encoding (IDLE=0, GRANT=1), requester count 4 and the index width 2.
REQ-028 The registered 4:1 data path SHALL be a sub-module mux4_reg (inputs data[3:0], sel, clk, rst_n; output out); the arbiter FSM lives in rr_mux_arb.
REQ-029 Round-robin search SHALL be combinational logic feeding the registered FSM; no latches.

Verification
REQ-030 Reset release, req=0001, data=0001 -> gnt=0001, sel=0 after first edge; out=1, out_vld=1 after second edge.
REQ-031 req=1111 held, MAX_HOLD=4 -> grant order 0,1,2,3,0 with each owner holding exactly 4 cycles, no idle cycle between owners.
REQ-032 req=0100 only, held 10 cycles, MAX_HOLD=4 -> sel=2 continuously, hold_cnt cycles 1..4, gnt never zero.
REQ-033 Owner 1 drops req at hold_cnt=2 while req[3]=1 -> next edge gnt=1000, sel=3, hold_cnt=1; out_vld low for the one cycle after drop.
REQ-034 Drop coinciding with hold expiry and req=0 elsewhere -> IDLE, gnt=0000, out_vld=0 next edge.
REQ-035 rst_n pulsed low mid-grant of requester 2 with req=1111 -> outputs zero asynchronously; after release first grant is requester 0.

Source files
------------

// File: rtl/rr_mux_arb_pkg.sv
// rtl/rr_mux_arb_pkg.sv - shared types, sizes and round-robin search for rr_mux_arb
package rr_mux_arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // First set request strictly after last, wrapping; last itself is checked at the end.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] win;
    logic             found;
    win   = last;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = last + IDX_W'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_mux_arb_mux4_reg.sv
// rtl/rr_mux_arb_mux4_reg.sv - registered 4:1 single-bit data mux
module mux4_reg
  import rr_mux_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] data,
  input  logic [IDX_W-1:0] sel,
  output logic             out
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out <= 1'b0;
    else        out <= data[sel];
  end

endmodule

// File: rtl/rr_mux_arb.sv
// rtl/rr_mux_arb.sv - round-robin arbiter with hold limit driving a registered 4:1 mux
module rr_mux_arb
  import rr_mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] data,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] sel,
  output logic             out,
  output logic             out_vld
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] sel_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [3:0]       hold_cnt, hold_d;
  logic [N_REQ-1:0] gnt_d;
  logic             vld_d;
  logic [IDX_W-1:0] pick;
  logic             any_req;

  assign pick    = rr_pick(req, last_q);
  assign any_req = |req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel      <= '0;
      last_q   <= IDX_W'(N_REQ - 1);
      hold_cnt <= 4'd0;
      gnt      <= '0;
      out_vld  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel      <= sel_d;
      last_q   <= last_d;
      hold_cnt <= hold_d;
      gnt      <= gnt_d;
      out_vld  <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel;
    last_d  = last_q;
    hold_d  = hold_cnt;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          sel_d   = pick;
          last_d  = pick;
          hold_d  = 4'd1;
        end
      end
      GRANT: begin
        if (req[sel] && (hold_cnt < 4'(MAX_HOLD))) begin
          hold_d = hold_cnt + 4'd1;
        end else if (any_req) begin
          // Re-arbitrate in place; an expiring sole requester is found again by the wrap.
          sel_d  = pick;
          last_d = pick;
          hold_d = 4'd1;
        end else begin
          state_d = IDLE;
          hold_d  = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d = '0;
    if (state_d == GRANT) gnt_d = N_REQ'(1) << sel_d;
    vld_d = (state_q == GRANT) && req[sel];
  end

  mux4_reg u_mux (
    .clk   (clk),
    .rst_n (rst_n),
    .data  (data),
    .sel   (sel),
    .out   (out)
  );

endmodule

// File: tb/tb_rr_mux_arb.sv
// tb/tb_rr_mux_arb.sv - scoreboard bench for rr_mux_arb
module tb_rr_mux_arb;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'h0;
  logic [3:0] data = 4'h0;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       out;
  logic       out_vld;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [3:0] hold;
    logic       out;
    logic       vld;
  } exp_t;

  exp_t sb[$];

  logic       m_grant;
  logic [1:0] m_sel;
  int         m_last;
  int         m_hold;

  rr_mux_arb #(.MAX_HOLD(MAXH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .data    (data),
    .gnt     (gnt),
    .sel     (sel),
    .out     (out),
    .out_vld (out_vld)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_grant = 1'b0;
    m_sel   = 2'd0;
    m_last  = 3;
    m_hold  = 0;
    sb.delete();
  endtask

  task automatic model_step(input logic [3:0] r, input logic [3:0] d);
    exp_t e;
    logic n_out;
    logic n_vld;
    logic rearb;
    n_out = d[m_sel];
    n_vld = m_grant && r[m_sel];
    rearb = 1'b0;
    if (!m_grant) begin
      rearb = (r != 4'h0);
    end else if (r[m_sel] && m_hold < MAXH) begin
      m_hold = m_hold + 1;
    end else if (r != 4'h0) begin
      rearb = 1'b1;
    end else begin
      m_grant = 1'b0;
      m_hold  = 0;
    end
    if (rearb) begin
      for (int k = 1; k <= 4; k++) begin
        if (r[(m_last + k) % 4]) begin
          m_sel = 2'((m_last + k) % 4);
          break;
        end
      end
      m_last  = int'(m_sel);
      m_grant = 1'b1;
      m_hold  = 1;
    end
    e.gnt  = m_grant ? (4'b0001 << m_sel) : 4'b0000;
    e.sel  = m_sel;
    e.hold = 4'(m_hold);
    e.out  = n_out;
    e.vld  = n_vld;
    sb.push_back(e);
  endtask

  task automatic cycle(input logic [3:0] r, input logic [3:0] d);
    exp_t e;
    req  = r;
    data = d;
    model_step(r, d);
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty actual=0 required=1");
    end else begin
      e = sb.pop_front();
      if ({gnt, sel, dut.hold_cnt, out, out_vld} !== e) begin
        errors++;
        $display("FAIL sb_cycle gnt=%b sel=%0d hold=%0d out=%b vld=%b required gnt=%b sel=%0d hold=%0d out=%b vld=%b",
                 gnt, sel, dut.hold_cnt, out, out_vld, e.gnt, e.sel, e.hold, e.out, e.vld);
      end
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (gnt !== 4'h0 || sel !== 2'd0 || out !== 1'b0 || out_vld !== 1'b0 || dut.hold_cnt !== 4'd0) begin
      errors++;
      $display("FAIL %s gnt=%b sel=%0d out=%b vld=%b hold=%0d required all zero",
               name, gnt, sel, out, out_vld, dut.hold_cnt);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req  = 4'hF;
    data = 4'hF;
    #2;
    check_zero("reset_initial");
    @(posedge clk);
    #1;
    check_zero("reset_held_through_edge");
    rst_n = 1'b1;
    model_reset();
    #3;
    check_zero("reset_release_before_edge");
  endtask

  task automatic test_first_grant();
    cycle(4'b0001, 4'b0001);
    checks++;
    if (gnt !== 4'b0001 || sel !== 2'd0) begin
      errors++;
      $display("FAIL first_grant gnt=%b sel=%0d required gnt=0001 sel=0", gnt, sel);
    end
    cycle(4'b0001, 4'b0001);
    checks++;
    if (out !== 1'b1 || out_vld !== 1'b1) begin
      errors++;
      $display("FAIL first_out out=%b vld=%b required out=1 vld=1", out, out_vld);
    end
  endtask

  task automatic test_rotation();
    do_reset();
    for (int i = 0; i <= 16; i++) begin
      cycle(4'hF, 4'($urandom));
      checks++;
      if (sel !== 2'((i / MAXH) % 4) || gnt === 4'h0) begin
        errors++;
        $display("FAIL rotation_%0d sel=%0d gnt=%b required sel=%0d gnt nonzero", i, sel, gnt, (i / MAXH) % 4);
      end
    end
  endtask

  task automatic test_single_hold();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(4'b0100, 4'($urandom));
      checks++;
      if (sel !== 2'd2 || gnt !== 4'b0100 || dut.hold_cnt !== 4'((i % MAXH) + 1)) begin
        errors++;
        $display("FAIL single_hold_%0d sel=%0d gnt=%b hold=%0d required sel=2 gnt=0100 hold=%0d",
                 i, sel, gnt, dut.hold_cnt, (i % MAXH) + 1);
      end
    end
  endtask

  task automatic test_drop_switch();
    do_reset();
    cycle(4'b0010, 4'hF);
    cycle(4'b1010, 4'hF);
    cycle(4'b1000, 4'hF);
    checks++;
    if (gnt !== 4'b1000 || sel !== 2'd3 || dut.hold_cnt !== 4'd1 || out_vld !== 1'b0) begin
      errors++;
      $display("FAIL drop_switch gnt=%b sel=%0d hold=%0d vld=%b required gnt=1000 sel=3 hold=1 vld=0",
               gnt, sel, dut.hold_cnt, out_vld);
    end
    cycle(4'b1000, 4'hF);
    checks++;
    if (out_vld !== 1'b1) begin
      errors++;
      $display("FAIL drop_switch_vld vld=%b required 1", out_vld);
    end
  endtask

  task automatic test_expiry_idle();
    do_reset();
    for (int i = 0; i < MAXH; i++) cycle(4'b0001, 4'h1);
    cycle(4'b0000, 4'h1);
    checks++;
    if (gnt !== 4'b0000 || out_vld !== 1'b0 || sel !== 2'd0) begin
      errors++;
      $display("FAIL expiry_idle gnt=%b vld=%b sel=%0d required gnt=0000 vld=0 sel=0", gnt, out_vld, sel);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 2 * MAXH + 1; i++) cycle(4'hF, 4'hF);
    checks++;
    if (sel !== 2'd2) begin
      errors++;
      $display("FAIL reset_mid_pre sel=%0d required 2", sel);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid_async");
    model_reset();
    rst_n = 1'b1;
    cycle(4'hF, 4'hF);
    checks++;
    if (sel !== 2'd0 || gnt !== 4'b0001) begin
      errors++;
      $display("FAIL reset_mid_regrant sel=%0d gnt=%b required sel=0 gnt=0001", sel, gnt);
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    do_reset();
    for (int i = 0; i < 120; i++) begin
      r = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      cycle(r, 4'($urandom));
      checks++;
      if (gnt !== 4'h0 && gnt !== (4'b0001 << sel)) begin
        errors++;
        $display("FAIL onehot_%0d gnt=%b sel=%0d required onehot(sel) or 0", i, gnt, sel);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_grant();
    test_rotation();
    test_single_hold();
    test_drop_switch();
    test_expiry_idle();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
